serial_adder_ctrl: RTL

Bit-serial N-bit adder, built from one full-adder bit cell (two half-adder stages plus an OR on the carries) and a registered carry.
- Accepts two WIDTH-bit operands on a start pulse.
- Adds them LSB-first, one bit per clock.
- Presents the WIDTH-bit Sum and the carry-out Count with a one-cycle done strobe.
- Sits downstream of the half-adder cell: it consumes per-bit Sum/Count and sequences them into multi-bit words for the next stage.

---
 rtl/serial_adder_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// ============================================================================
// serial_adder_ctrl : bit-serial WIDTH-bit adder, LSB first, one full-adder cell
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sa_half_adder (
   input  logic a_i,
   input  logic b_i,
   output logic s_o,
   output logic c_o
);
   assign s_o = a_i ^ b_i;
   assign c_o = a_i & b_i;
endmodule

module sa_full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);
   logic w_s0;
   logic w_c0;
   logic w_c1;

   sa_half_adder u_ha0 (.a_i(a_i),  .b_i(b_i), .s_o(w_s0), .c_o(w_c0));
   sa_half_adder u_ha1 (.a_i(w_s0), .b_i(c_i), .s_o(s_o),  .c_o(w_c1));

   assign c_o = w_c0 | w_c1;
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Count
);
   localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] sum_q;
   logic             count_q;

   logic             bit_s;
   logic             carry_d;
   logic [WIDTH-1:0] res_d;
   logic             w_accept;
   logic             w_run;
   logic             w_last;

   sa_full_adder u_fa (
      .a_i (a_q[0]),
      .b_i (b_q[0]),
      .c_i (carry_q),
      .s_o (bit_s),
      .c_o (carry_d)
   );

   assign w_accept = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;
   assign w_run    = (state_q == ST_RUN);
   assign w_last   = (cnt_q == LAST);

   // The LSB of the result word would be shifted out unread, so only the upper
   // WIDTH-1 partial bits are stored; res_d is the word after the current bit.
   generate
      if (WIDTH == 1) begin : g_res_w1
         assign res_d = bit_s;
      end else begin : g_res_wn
         logic [WIDTH-2:0] part_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               part_q <= '0;
            end else if (w_accept) begin
               part_q <= '0;
            end else if (w_run) begin
               part_q <= res_d[WIDTH-1:1];
            end
         end

         assign res_d = {bit_s, part_q};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         count_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= A;
                  b_q     <= B;
                  carry_q <= 1'b0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_RUN: begin
               a_q     <= a_q >> 1;
               b_q     <= b_q >> 1;
               carry_q <= carry_d;
               if (w_last) begin
                  sum_q   <= res_d;
                  count_q <= carry_d;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign Sum   = sum_q;
   assign Count = count_q;

endmodule

`default_nettype wire
